// File: rtl/square_sweep_unit_if.sv
// Interface bundling the strobes, data and shifter handshake of square_sweep_unit.
// The slave side is the sweep unit; the master side is the CPU/frame-counter/shifter.
interface square_sweep_unit_if;
  logic        HALF_FRAME;
  logic        W_SWEEP;
  logic        W_FLO;
  logic        W_FHI;
  logic [7:0]  DIN;
  logic [10:0] S;
  logic [10:0] F;
  logic [2:0]  SR;
  logic        MUTE;
  logic        TICK;

  modport master (
    output HALF_FRAME, W_SWEEP, W_FLO, W_FHI, DIN, S,
    input  F, SR, MUTE, TICK
  );

  modport slave (
    input  HALF_FRAME, W_SWEEP, W_FLO, W_FHI, DIN, S,
    output F, SR, MUTE, TICK
  );
endinterface

// File: rtl/square_sweep_unit.sv
// Frequency/sweep stage of an APU square channel.
// Holds the 11-bit frequency F, feeds F and SR to the barrel shifter, builds the
// sweep target F +/- S, steps F on half-frame strobes and reports sweep mute.
// NEG_CARRY selects the negate flavour: 0 = square 1 (F - S - 1), 1 = square 2 (F - S).
// Optional macro SQUARE_SWEEP_TIMER_EN adds the channel period timer driving TICK;
// without it TICK is tied low.
module square_sweep_unit #(
  parameter bit NEG_CARRY = 1'b0
) (
  input  logic               ACLK,
  input  logic               RES,
  square_sweep_unit_if.slave bus
);

  logic [10:0] f_q, f_d;
  logic [2:0]  sr_q, sr_d;
  logic        enable_q, enable_d;
  logic        negate_q, negate_d;
  logic [2:0]  period_q, period_d;
  logic [2:0]  divider_q, divider_d;
  logic        reload_q, reload_d;

  logic [10:0] s_operand;
  logic        carry_in;
  logic [11:0] sum;
  logic [10:0] target;
  logic        mute;
  logic        divider_zero;
  logic        sweep_fire;

  // Sweep adder: add or ones'/two's-complement subtract the shifter output; overflow only mutes when adding.
  always_comb begin
    s_operand = bus.S;
    carry_in  = 1'b0;
    if (negate_q) begin
      s_operand = ~bus.S;
      carry_in  = NEG_CARRY;
    end
    sum    = {1'b0, f_q} + {1'b0, s_operand} + {11'd0, carry_in};
    target = sum[10:0];
    mute   = (f_q < 11'd8) | (~negate_q & sum[11]);
  end

  // A half-frame retunes F only when the divider has expired and the sweep is live and unmuted.
  always_comb begin
    divider_zero = (divider_q == 3'd0);
    sweep_fire   = bus.HALF_FRAME & divider_zero & enable_q & (sr_q != 3'd0) & ~mute;
  end

  // Next state: sweep step and divider first, then CPU writes so a written byte or field wins.
  always_comb begin
    f_d       = f_q;
    sr_d      = sr_q;
    enable_d  = enable_q;
    negate_d  = negate_q;
    period_d  = period_q;
    divider_d = divider_q;
    reload_d  = reload_q;

    if (sweep_fire) begin
      f_d = target;
    end

    if (bus.HALF_FRAME) begin
      if (divider_zero || reload_q) begin
        divider_d = period_q;
        reload_d  = 1'b0;
      end else begin
        divider_d = divider_q - 3'd1;
      end
    end

    if (bus.W_FLO) begin
      f_d[7:0] = bus.DIN;
    end

    if (bus.W_FHI) begin
      f_d[10:8] = bus.DIN[2:0];
    end

    if (bus.W_SWEEP) begin
      enable_d = bus.DIN[7];
      period_d = bus.DIN[6:4];
      negate_d = bus.DIN[3];
      sr_d     = bus.DIN[2:0];
      reload_d = 1'b1;
    end
  end

  // Sweep state registers; reset dominates every strobe.
  always_ff @(posedge ACLK) begin
    if (RES) begin
      f_q       <= 11'd0;
      sr_q      <= 3'd0;
      enable_q  <= 1'b0;
      negate_q  <= 1'b0;
      period_q  <= 3'd0;
      divider_q <= 3'd0;
      reload_q  <= 1'b0;
    end else begin
      f_q       <= f_d;
      sr_q      <= sr_d;
      enable_q  <= enable_d;
      negate_q  <= negate_d;
      period_q  <= period_d;
      divider_q <= divider_d;
      reload_q  <= reload_d;
    end
  end

`ifdef SQUARE_SWEEP_TIMER_EN
  logic [10:0] timer_q, timer_d;
  logic        tick_q, tick_d;

  // Period timer: count down, reload from the current F at zero and flag that reload on TICK.
  always_comb begin
    timer_d = timer_q - 11'd1;
    tick_d  = 1'b0;
    if (timer_q == 11'd0) begin
      timer_d = f_q;
      tick_d  = 1'b1;
    end
  end

  // Timer registers; F writes never touch the running count.
  always_ff @(posedge ACLK) begin
    if (RES) begin
      timer_q <= 11'd0;
      tick_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.TICK = tick_q;
`else
  assign bus.TICK = 1'b0;
`endif

  assign bus.F    = f_q;
  assign bus.SR   = sr_q;
  assign bus.MUTE = mute;

endmodule

// File: tb/tb_square_sweep_unit.sv
// Testbench for square_sweep_unit: two instances (NEG_CARRY 0 and 1) share stimulus;
// the shifter is modelled as S = F >> SR. Directed cases plus randomized traffic
// against an arithmetic reference model.
module tb_square_sweep_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res;
  logic       half_frame;
  logic       w_sweep;
  logic       w_flo;
  logic       w_fhi;
  logic [7:0] din;

  int tests_run    = 0;
  int tests_failed = 0;

  square_sweep_unit_if bus0 ();
  square_sweep_unit_if bus1 ();

  assign bus0.HALF_FRAME = half_frame;
  assign bus0.W_SWEEP    = w_sweep;
  assign bus0.W_FLO      = w_flo;
  assign bus0.W_FHI      = w_fhi;
  assign bus0.DIN        = din;
  assign bus0.S          = bus0.F >> bus0.SR;

  assign bus1.HALF_FRAME = half_frame;
  assign bus1.W_SWEEP    = w_sweep;
  assign bus1.W_FLO      = w_flo;
  assign bus1.W_FHI      = w_fhi;
  assign bus1.DIN        = din;
  assign bus1.S          = bus1.F >> bus1.SR;

  square_sweep_unit #(.NEG_CARRY(1'b0)) dut0 (.ACLK(clk), .RES(res), .bus(bus0));
  square_sweep_unit #(.NEG_CARRY(1'b1)) dut1 (.ACLK(clk), .RES(res), .bus(bus1));

  logic [10:0] obs_f    [2];
  logic [2:0]  obs_sr   [2];
  logic        obs_mute [2];
  logic        obs_tick [2];

  assign obs_f[0]    = bus0.F;
  assign obs_f[1]    = bus1.F;
  assign obs_sr[0]   = bus0.SR;
  assign obs_sr[1]   = bus1.SR;
  assign obs_mute[0] = bus0.MUTE;
  assign obs_mute[1] = bus1.MUTE;
  assign obs_tick[0] = bus0.TICK;
  assign obs_tick[1] = bus1.TICK;

  // Reference model state, index = NEG_CARRY of the instance
  int m_f [2], m_sr [2], m_period [2], m_div [2], m_timer [2];
  bit m_en [2], m_neg [2], m_reload [2], m_tick [2];

  function automatic bit model_mute(int c);
    int s;
    s = m_f[c] >> m_sr[c];
    return (m_f[c] < 8) || (!m_neg[c] && (m_f[c] + s) > 2047);
  endfunction

  function automatic int model_target(int c);
    int s;
    int t;
    s = m_f[c] >> m_sr[c];
    if (!m_neg[c]) t = m_f[c] + s;
    else           t = m_f[c] - s - ((c == 0) ? 1 : 0);
    return t & 'h7FF;
  endfunction

  task automatic model_apply();
    for (int c = 0; c < 2; c++) begin
      int  nf;
      int  old_f;
      bit  fire;
      if (res) begin
        m_f[c] = 0; m_sr[c] = 0; m_period[c] = 0; m_div[c] = 0; m_timer[c] = 0;
        m_en[c] = 0; m_neg[c] = 0; m_reload[c] = 0; m_tick[c] = 0;
      end else begin
        old_f = m_f[c];
        nf    = m_f[c];
        fire  = half_frame && (m_div[c] == 0) && m_en[c] && (m_sr[c] != 0) && !model_mute(c);
        if (fire) nf = model_target(c);
        if (half_frame) begin
          if (m_div[c] == 0 || m_reload[c]) begin
            m_div[c]    = m_period[c];
            m_reload[c] = 0;
          end else begin
            m_div[c] = m_div[c] - 1;
          end
        end
        if (w_flo) nf = (nf & 'h700) | int'(din);
        if (w_fhi) nf = (nf & 'h0FF) | ((int'(din) & 7) << 8);
        if (w_sweep) begin
          m_en[c]     = din[7];
          m_period[c] = (int'(din) >> 4) & 7;
          m_neg[c]    = din[3];
          m_sr[c]     = int'(din) & 7;
          m_reload[c] = 1;
        end
        m_f[c] = nf;
`ifdef SQUARE_SWEEP_TIMER_EN
        if (m_timer[c] == 0) begin
          m_timer[c] = old_f;
          m_tick[c]  = 1;
        end else begin
          m_timer[c] = m_timer[c] - 1;
          m_tick[c]  = 0;
        end
`else
        m_tick[c] = 0;
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_apply();
    #1;
    res = 0; half_frame = 0; w_sweep = 0; w_flo = 0; w_fhi = 0;
  endtask

  task automatic do_reset();
    res = 1;
    step();
  endtask

  task automatic write_f(input logic [10:0] v);
    w_flo = 1; din = v[7:0];
    step();
    w_fhi = 1; din = {5'b11111, v[10:8]};
    step();
  endtask

  task automatic write_sweep(input logic [7:0] d);
    w_sweep = 1; din = d;
    step();
  endtask

  task automatic pulse_hf();
    half_frame = 1;
    step();
  endtask

  task automatic test_reset();
    res = 1; half_frame = 1; w_sweep = 1; w_flo = 1; w_fhi = 1; din = 8'hFF;
    step();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== 11'h000) begin tests_failed++; $display("[TB] FAIL reset_f[%0d]: got %h expected 000", c, obs_f[c]); end
      tests_run++;
      if (obs_sr[c] !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_sr[%0d]: got %0d expected 0", c, obs_sr[c]); end
      tests_run++;
      if (obs_mute[c] !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_mute[%0d]: got %b expected 1", c, obs_mute[c]); end
      tests_run++;
      if (obs_tick[c] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tick[%0d]: got %b expected 0", c, obs_tick[c]); end
    end
  endtask

  task automatic test_add_path();
    do_reset();
    write_f(11'h100);
    write_sweep(8'h81);
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== 11'h100) begin tests_failed++; $display("[TB] FAIL add_pre_f[%0d]: got %h expected 100", c, obs_f[c]); end
    end
    pulse_hf();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== 11'h180) begin tests_failed++; $display("[TB] FAIL add_f[%0d]: got %h expected 180", c, obs_f[c]); end
      tests_run++;
      if (obs_mute[c] !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_mute[%0d]: got %b expected 0", c, obs_mute[c]); end
    end
  endtask

  task automatic test_negate();
    logic [10:0] exp_f [2];
    exp_f[0] = 11'h07F;
    exp_f[1] = 11'h080;
    do_reset();
    write_f(11'h100);
    write_sweep(8'h88);
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_mute[c] !== 1'b0) begin tests_failed++; $display("[TB] FAIL neg_carry_ignored_mute[%0d]: got %b expected 0", c, obs_mute[c]); end
    end
    write_sweep(8'h89);
    pulse_hf();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== exp_f[c]) begin tests_failed++; $display("[TB] FAIL neg_f[%0d]: got %h expected %h", c, obs_f[c], exp_f[c]); end
      tests_run++;
      if (obs_mute[c] !== 1'b0) begin tests_failed++; $display("[TB] FAIL neg_mute[%0d]: got %b expected 0", c, obs_mute[c]); end
    end
  endtask

  task automatic test_overflow_mute();
    do_reset();
    write_f(11'h600);
    write_sweep(8'h81);
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_mute[c] !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_mute[%0d]: got %b expected 1", c, obs_mute[c]); end
    end
    pulse_hf();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== 11'h600) begin tests_failed++; $display("[TB] FAIL ovf_f[%0d]: got %h expected 600", c, obs_f[c]); end
    end
    write_f(11'h007);
    for (int sh = 0; sh < 8; sh++) begin
      write_sweep(8'h80 | 8'(($urandom % 2) << 3) | 8'(sh));
      for (int c = 0; c < 2; c++) begin
        tests_run++;
        if (obs_mute[c] !== 1'b1) begin tests_failed++; $display("[TB] FAIL low_f_mute[%0d] shift %0d: got %b expected 1", c, sh, obs_mute[c]); end
      end
    end
  endtask

  task automatic test_divider();
    logic [10:0] exp_f [7];
    exp_f = '{11'h200, 11'h200, 11'h200, 11'h220, 11'h220, 11'h220, 11'h242};
    do_reset();
    write_f(11'h200);
    write_sweep(8'h24);
    pulse_hf();
    write_sweep(8'hA4);
    for (int p = 0; p < 7; p++) begin
      pulse_hf();
      step();
      for (int c = 0; c < 2; c++) begin
        tests_run++;
        if (obs_f[c] !== exp_f[p]) begin tests_failed++; $display("[TB] FAIL div_pulse%0d_f[%0d]: got %h expected %h", p + 1, c, obs_f[c], exp_f[p]); end
      end
    end
  endtask

  task automatic test_collision();
    // W_SWEEP together with HALF_FRAME
    do_reset();
    write_f(11'h100);
    write_sweep(8'h91);
    half_frame = 1; w_sweep = 1; din = 8'hB2;
    step();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== 11'h180) begin tests_failed++; $display("[TB] FAIL coll_sweep_f[%0d]: got %h expected 180", c, obs_f[c]); end
      tests_run++;
      if (obs_sr[c] !== 3'd2) begin tests_failed++; $display("[TB] FAIL coll_sweep_sr[%0d]: got %0d expected 2", c, obs_sr[c]); end
    end
    for (int p = 0; p < 2; p++) begin
      pulse_hf();
      for (int c = 0; c < 2; c++) begin
        tests_run++;
        if (obs_f[c] !== 11'h180) begin tests_failed++; $display("[TB] FAIL coll_reload_pulse%0d_f[%0d]: got %h expected 180", p + 2, c, obs_f[c]); end
      end
    end
    // W_FHI together with a step
    do_reset();
    write_f(11'h100);
    write_sweep(8'h81);
    half_frame = 1; w_fhi = 1; din = 8'hFD;
    step();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== 11'h580) begin tests_failed++; $display("[TB] FAIL coll_fhi_f[%0d]: got %h expected 580", c, obs_f[c]); end
    end
    // RES mid-count
    do_reset();
    write_f(11'h100);
    write_sweep(8'hF1);
    pulse_hf();
    pulse_hf();
    res = 1; half_frame = 1; w_flo = 1; din = 8'hAA;
    step();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== 11'h000 || obs_sr[c] !== 3'd0 || obs_mute[c] !== 1'b1 || obs_tick[c] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL midreset[%0d]: got F=%h SR=%0d MUTE=%b TICK=%b expected F=000 SR=0 MUTE=1 TICK=0",
                 c, obs_f[c], obs_sr[c], obs_mute[c], obs_tick[c]);
      end
    end
    write_f(11'h100);
    pulse_hf();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== 11'h100) begin tests_failed++; $display("[TB] FAIL midreset_enable_f[%0d]: got %h expected 100", c, obs_f[c]); end
    end
    write_sweep(8'h81);
    pulse_hf();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs_f[c] !== 11'h180) begin tests_failed++; $display("[TB] FAIL midreset_divider_f[%0d]: got %h expected 180", c, obs_f[c]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      res        = ($urandom_range(0, 79) == 0);
      half_frame = ($urandom_range(0, 3) == 0);
      w_sweep    = ($urandom_range(0, 9) == 0);
      w_flo      = ($urandom_range(0, 7) == 0);
      w_fhi      = ($urandom_range(0, 7) == 0);
      din        = 8'($urandom);
      step();
      for (int c = 0; c < 2; c++) begin
        tests_run++;
        if (obs_f[c] !== 11'(m_f[c])) begin tests_failed++; $display("[TB] FAIL rand_f[%0d] cycle %0d: got %h expected %h", c, i, obs_f[c], 11'(m_f[c])); end
        tests_run++;
        if (obs_sr[c] !== 3'(m_sr[c])) begin tests_failed++; $display("[TB] FAIL rand_sr[%0d] cycle %0d: got %0d expected %0d", c, i, obs_sr[c], m_sr[c]); end
        tests_run++;
        if (obs_mute[c] !== model_mute(c)) begin tests_failed++; $display("[TB] FAIL rand_mute[%0d] cycle %0d: got %b expected %b", c, i, obs_mute[c], model_mute(c)); end
        tests_run++;
        if (obs_tick[c] !== m_tick[c]) begin tests_failed++; $display("[TB] FAIL rand_tick[%0d] cycle %0d: got %b expected %b", c, i, obs_tick[c], m_tick[c]); end
      end
    end
  endtask

`ifdef SQUARE_SWEEP_TIMER_EN
  task automatic wait_tick(output int cycles, output bit ok);
    cycles = 0;
    ok     = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      cycles++;
      if (obs_tick[0] === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_timer();
    int gap;
    bit ok;
    int exp_gap [4];
    exp_gap = '{4, 4, 4, 2};
    do_reset();
    write_f(11'h003);
    wait_tick(gap, ok);
    for (int g = 0; g < 2; g++) begin
      wait_tick(gap, ok);
      tests_run++;
      if (!ok || gap !== exp_gap[g]) begin tests_failed++; $display("[TB] FAIL timer_gap%0d: got %0d (seen=%b) expected %0d", g, gap, ok, exp_gap[g]); end
    end
    w_flo = 1; din = 8'h01;
    step();
    wait_tick(gap, ok);
    gap = gap + 1;
    tests_run++;
    if (!ok || gap !== exp_gap[2]) begin tests_failed++; $display("[TB] FAIL timer_gap_after_write: got %0d (seen=%b) expected %0d", gap, ok, exp_gap[2]); end
    for (int g = 0; g < 2; g++) begin
      wait_tick(gap, ok);
      tests_run++;
      if (!ok || gap !== exp_gap[3]) begin tests_failed++; $display("[TB] FAIL timer_gap_new%0d: got %0d (seen=%b) expected %0d", g, gap, ok, exp_gap[3]); end
    end
  endtask
`endif

  initial begin
    res = 1; half_frame = 0; w_sweep = 0; w_flo = 0; w_fhi = 0; din = 8'h00;
    test_reset();
    test_add_path();
    test_negate();
    test_overflow_mute();
    test_divider();
    test_collision();
`ifdef SQUARE_SWEEP_TIMER_EN
    test_timer();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/square_sweep_unit.md
Name: square_sweep_unit

Overview:
- Frequency/sweep stage of an APU square channel, directly downstream of the square barrel shifter.
- Holds the 11-bit channel frequency F and drives F and the shift amount SR into the shifter.
- Consumes the shifted value S and computes the sweep target F ± S.
- Steps F on half-frame strobes, flags mute conditions, and optionally runs the channel period timer.

Parameters:
- NEG_CARRY, 0, carry-in of the negate path. 0 = square 1 (ones' complement, F - S - 1); 1 = square 2 (two's complement, F - S).

Ports:
- ACLK  in  1  clock; all state updates on rising edge.
- RES  in  1  synchronous active-high reset.
- HALF_FRAME  in  1  one-cycle strobe from the frame counter.
- W_SWEEP  in  1  write strobe, sweep register ($4001/$4005).
- W_FLO  in  1  write strobe, frequency low ($4002/$4006).
- W_FHI  in  1  write strobe, frequency high ($4003/$4007).
- DIN  in  8  CPU write data.
- S  in  11  shifted frequency returned by the barrel shifter; combinational function of F and SR within the same cycle.
- F  out  11  current frequency register, to the shifter and to the timer.
- SR  out  3  sweep shift count, to the shifter.
- MUTE  out  1  combinational sweep mute.
- TICK  out  1  period-timer pulse; see Optional Feature.

Behaviour:
- Reset: F=0, SR=0, enable=0, negate=0, period=0, divider=0, reload=0, timer=0, TICK=0. MUTE is therefore 1, because F<8.
- W_SWEEP:
  - enable=DIN[7], period=DIN[6:4], negate=DIN[3], SR=DIN[2:0].
  - Sets reload=1.
- W_FLO: F[7:0]=DIN.
- W_FHI: F[10:8]=DIN[2:0]. DIN[7:3] is ignored here; it belongs to the length counter.
- Adder (combinational, 12-bit):
  - negate=0: SUM = {0,F} + {0,S}.
  - negate=1: SUM = {0,F} + {0,~S} + NEG_CARRY.
  - TARGET = SUM[10:0].
- MUTE = (F < 8) | (~negate & SUM[11]).
  - MUTE is evaluated even when enable=0 or SR=0.
  - The carry is ignored when negate=1.
- Half-frame step, when HALF_FRAME=1:
  - If divider==0 & enable & SR!=0 & ~MUTE: F <= TARGET.
  - If divider==0 | reload: divider <= period and reload <= 0. Otherwise divider <= divider-1.
- Latency: F update is visible on the cycle after the HALF_FRAME edge.
- Simultaneous events:
  - W_FLO/W_FHI in the same cycle as a sweep step: the CPU write wins for the written byte. A non-written byte takes TARGET's bits.
  - W_SWEEP with HALF_FRAME in the same cycle: the step uses pre-write enable/negate/SR/period/divider. The new fields and reload=1 apply afterwards, and reload=1 overrides the divider's clear of reload.
  - RES asserted with any strobe: reset wins.
  - RES mid-sequence (divider nonzero): all state returns to reset values on the next edge.
- Wrap: divider is 3-bit and does not underflow; the reload branch covers 0.

Optional Feature:
- Macro: SQUARE_SWEEP_TIMER_EN.
- Defined:
  - An 11-bit down-counter timer runs every ACLK.
  - When timer==0: timer <= F and TICK=1 for that cycle; otherwise timer decrements and TICK=0.
  - TICK therefore has period F+1 cycles.
  - Writes to F do not reload the timer; the new F takes effect at the next zero.
  - RES clears the timer.
- Undefined: TICK is tied 0 and the timer logic is absent. All other behaviour is identical.

Test Plan:
- The bench models S = F >> SR, or instantiates the real shifter.
- Case 1, add path: write F=0x100, sweep DIN=0x81 (enable, period 0, shift 1), then one HALF_FRAME. Expect F=0x180 next cycle, MUTE=0.
- Case 2, negate path: F=0x100, sweep DIN=0x89, one HALF_FRAME.
  - NEG_CARRY=0: F=0x07F.
  - NEG_CARRY=1: F=0x080.
- Case 3, overflow mute: F=0x600, shift 1, negate 0. SUM=0x900, so MUTE=1. A HALF_FRAME leaves F=0x600.
  - Then F=0x007: MUTE=1 for any shift.
- Case 4, divider timing: F=0x200, sweep DIN=0xA4 (period 2, shift 4), then 7 HALF_FRAMEs.
  - The first pulse reloads the divider without stepping.
  - F updates on pulses 4 and 7: 0x200 → 0x220 → 0x242.
- Case 5, collision and reset:
  - W_SWEEP together with HALF_FRAME: the step uses the old fields and reload is set after.
  - W_FHI together with a step: F[10:8]=DIN[2:0], F[7:0]=TARGET[7:0].
  - RES pulse mid-count: all outputs return to reset values.
- Case 6 (SQUARE_SWEEP_TIMER_EN): F=3, so TICK pulses every 4 cycles. Change F to 1 mid-count: the remaining count finishes, then TICK pulses every 2 cycles.
